// File: rtl/pt_dec.sv
// PT2262-style tri-state frame decoder: measures run lengths on a synchronized line,
// rebuilds twelve 2-bit code bits and qualifies each frame by its sync bit.
// Optional PT_DEC_MATCH2_EN: a word is published only after two identical frames.
module pt_dec #(
  parameter int SHORT    = 4,
  parameter int LONG     = 12,
  parameter int TOL      = 2,
  parameter int SYNC_MIN = 64,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  output logic [23:0] ad,
  output logic        valid,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, ARMED, HI, LO, SYNC_HI, SYNC_LO} state_t;

  localparam logic [CNT_W-1:0] S_MIN  = CNT_W'(SHORT - TOL);
  localparam logic [CNT_W-1:0] S_MAX  = CNT_W'(SHORT + TOL);
  localparam logic [CNT_W-1:0] L_MIN  = CNT_W'(LONG - TOL);
  localparam logic [CNT_W-1:0] L_MAX  = CNT_W'(LONG + TOL);
  localparam logic [CNT_W-1:0] SYNC_M = CNT_W'(SYNC_MIN);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [1:0] C_S = 2'd0, C_L = 2'd1, C_BAD = 2'd2;

  state_t           state, state_n;
  logic             din_p0, din_p1;
  logic [CNT_W-1:0] hcnt, hcnt_n, lcnt, lcnt_n;
  logic [4:0]       idx, idx_n;
  logic [23:0]      shift, shift_n;
  logic             first, first_n;
  logic             take, fail;
  logic [1:0]       sym;
  logic             s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + ONE;
  endfunction

  function automatic logic [1:0] run_class(input logic [CNT_W-1:0] r);
    if (r >= S_MIN && r <= S_MAX) return C_S;
    if (r >= L_MIN && r <= L_MAX) return C_L;
    return C_BAD;
  endfunction

  // A pulse is legal only as short-high/long-low or long-high/short-low.
  function automatic logic [1:0] pulse_sym(input logic [CNT_W-1:0] h,
                                           input logic [CNT_W-1:0] l);
    if (run_class(h) == C_S && run_class(l) == C_L) return C_S;
    if (run_class(h) == C_L && run_class(l) == C_S) return C_L;
    return C_BAD;
  endfunction

  assign s   = din_p1;
  assign sym = pulse_sym(hcnt, lcnt);

  always_comb begin
    state_n = state;
    hcnt_n  = hcnt;
    lcnt_n  = lcnt;
    idx_n   = idx;
    shift_n = shift;
    first_n = first;
    take    = 1'b0;
    fail    = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          if (lcnt == SYNC_M) begin
            state_n = HI;
            hcnt_n  = ONE;
            idx_n   = '0;
          end else begin
            lcnt_n = '0;
          end
        end else if (lcnt == SYNC_M) begin
          state_n = ARMED;
        end else begin
          lcnt_n = sat_inc(lcnt);
        end
      end
      ARMED: begin
        if (s) begin
          state_n = HI;
          hcnt_n  = ONE;
          idx_n   = '0;
        end
      end
      HI: begin
        if (s) begin
          hcnt_n = sat_inc(hcnt);
        end else begin
          lcnt_n  = ONE;
          state_n = LO;
        end
      end
      LO: begin
        if (!s) begin
          if (lcnt == SYNC_M) fail = 1'b1;
          else lcnt_n = sat_inc(lcnt);
        end else begin
          hcnt_n = ONE;
          if (sym == C_BAD) begin
            fail = 1'b1;
          end else if (idx[0]) begin
            // Pair (first, second): SS->00, LL->01, SL->10; LS is undecodable.
            if (first && !sym[0]) fail = 1'b1;
            else shift_n = {shift[21:0], ~first & sym[0], first & sym[0]};
          end else begin
            first_n = sym[0];
          end
          if (!fail) begin
            idx_n   = idx + 5'd1;
            state_n = (idx == 5'd23) ? SYNC_HI : HI;
          end
        end
      end
      SYNC_HI: begin
        if (s) begin
          hcnt_n = sat_inc(hcnt);
        end else if (run_class(hcnt) != C_S) begin
          fail = 1'b1;
        end else begin
          lcnt_n  = ONE;
          state_n = SYNC_LO;
        end
      end
      SYNC_LO: begin
        // The qualifying gap doubles as the next frame's preamble.
        if (lcnt == SYNC_M) begin
          take = 1'b1;
          if (s) begin
            state_n = HI;
            hcnt_n  = ONE;
            idx_n   = '0;
          end else begin
            state_n = ARMED;
          end
        end else if (s) begin
          fail = 1'b1;
        end else begin
          lcnt_n = sat_inc(lcnt);
        end
      end
      default: state_n = IDLE;
    endcase
    if (fail) begin
      state_n = IDLE;
      hcnt_n  = '0;
      lcnt_n  = '0;
      idx_n   = '0;
      shift_n = '0;
    end
  end

`ifdef PT_DEC_MATCH2_EN
  logic [23:0] cand;
  logic        cand_vld;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      din_p0 <= 1'b0;
      din_p1 <= 1'b0;
      state  <= IDLE;
      hcnt   <= '0;
      lcnt   <= '0;
      idx    <= '0;
      shift  <= '0;
      first  <= 1'b0;
      ad     <= '0;
      valid  <= 1'b0;
      err    <= 1'b0;
`ifdef PT_DEC_MATCH2_EN
      cand     <= '0;
      cand_vld <= 1'b0;
`endif
    end else begin
      din_p0 <= din;
      din_p1 <= din_p0;
      state  <= state_n;
      hcnt   <= hcnt_n;
      lcnt   <= lcnt_n;
      idx    <= idx_n;
      shift  <= shift_n;
      first  <= first_n;
      err    <= fail;
`ifdef PT_DEC_MATCH2_EN
      valid <= 1'b0;
      if (fail) cand_vld <= 1'b0;
      if (take) begin
        if (cand_vld && cand == shift) begin
          ad       <= shift;
          valid    <= 1'b1;
          cand_vld <= 1'b0;
        end else begin
          cand     <= shift;
          cand_vld <= 1'b1;
        end
      end
`else
      valid <= take;
      if (take) ad <= shift;
`endif
    end
  end

endmodule

// File: tb/tb_pt_dec.sv
// Directed bench for pt_dec: drives encoder-shaped frames and checks strobes,
// decoded words, timing and error handling against hand-computed values.
module tb_pt_dec;
  localparam int SHORT = 4, LONG = 12, SYNC_LOW = 31 * 4;

  logic        clk = 1'b0, rst = 1'b1, din = 1'b0;
  logic [23:0] ad;
  logic        valid, err;

  int checks = 0, errors = 0;
  int cyc = 0, nvalid = 0, nerr = 0, nboth = 0, fall_cyc = 0;
  logic [23:0] vad [64];
  int          vcyc [64];

  pt_dec dut (.clk(clk), .rst(rst), .din(din), .ad(ad), .valid(valid), .err(err));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      vad[nvalid % 64]  <= ad;
      vcyc[nvalid % 64] <= cyc;
      nvalid <= nvalid + 1;
    end
    if (err) nerr <= nerr + 1;
    if (valid && err) nboth <= nboth + 1;
  end

  task automatic level(input logic v, input int n);
    repeat (n) begin
      din = v;
      @(negedge clk);
    end
  endtask

  task automatic pulse(input int h, input int l);
    level(1'b1, h);
    level(1'b0, l);
  endtask

  // Each code bit is two pulses; code 11 is sent as a 1-clk-high pulse.
  task automatic send_frame(input logic [23:0] w, input int sh, input int sl,
                            input int lh, input int ll, input int rst_at);
    logic [1:0] c;
    logic       sym [2];
    int         p;
    p = 0;
    for (int i = 11; i >= 0; i--) begin
      c = w[2*i+1 -: 2];
      sym[0] = (c == 2'b01);
      sym[1] = (c != 2'b00);
      for (int k = 0; k < 2; k++) begin
        if (p == rst_at) rst = 1'b1;
        if (c == 2'b11 && k == 0) pulse(1, 15);
        else if (sym[k]) pulse(lh, ll);
        else pulse(sh, sl);
        rst = 1'b0;
        p++;
      end
    end
    level(1'b1, SHORT);
    fall_cyc = cyc;
    level(1'b0, SYNC_LOW);
  endtask

  task automatic nominal(input logic [23:0] w);
    send_frame(w, SHORT, LONG, LONG, SHORT, -1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (ad !== 24'h0) begin errors++; $display("FAIL reset_ad got %h want 000000", ad); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int v0, e0;
    v0 = nvalid; e0 = nerr;
    level(1'b0, 400);
    nominal(24'h5A5A5A);
    checks++; if (nvalid - v0 !== 1) begin errors++; $display("FAIL basic_count got %0d want 1", nvalid - v0); end
    checks++; if (ad !== 24'h5A5A5A) begin errors++; $display("FAIL basic_ad got %h want 5a5a5a", ad); end
    checks++; if (nerr - e0 !== 0) begin errors++; $display("FAIL basic_err got %0d want 0", nerr - e0); end
    checks++;
    if (vcyc[v0 % 64] - fall_cyc !== 67) begin
      errors++; $display("FAIL basic_latency got %0d want 67", vcyc[v0 % 64] - fall_cyc);
    end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = nvalid;
    nominal(24'h000000);
    nominal(24'h955555);
    checks++; if (nvalid - v0 !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", nvalid - v0); end
    checks++; if (vad[v0 % 64] !== 24'h000000) begin errors++; $display("FAIL b2b_ad0 got %h want 000000", vad[v0 % 64]); end
    checks++; if (vad[(v0 + 1) % 64] !== 24'h955555) begin errors++; $display("FAIL b2b_ad1 got %h want 955555", vad[(v0 + 1) % 64]); end
    checks++;
    if (vcyc[(v0 + 1) % 64] - vcyc[v0 % 64] !== 512) begin
      errors++; $display("FAIL b2b_spacing got %0d want 512", vcyc[(v0 + 1) % 64] - vcyc[v0 % 64]);
    end
  endtask

  task automatic test_bad_code;
    int v0, e0;
    v0 = nvalid; e0 = nerr;
    nominal(24'hC00000);
    checks++; if (nerr - e0 !== 1) begin errors++; $display("FAIL bad_err got %0d want 1", nerr - e0); end
    checks++; if (nvalid - v0 !== 0) begin errors++; $display("FAIL bad_valid got %0d want 0", nvalid - v0); end
    checks++; if (ad !== 24'h955555) begin errors++; $display("FAIL bad_ad_hold got %h want 955555", ad); end
    nominal(24'h6A1942);
    checks++; if (nvalid - v0 !== 1) begin errors++; $display("FAIL bad_recover_count got %0d want 1", nvalid - v0); end
    checks++; if (ad !== 24'h6A1942) begin errors++; $display("FAIL bad_recover_ad got %h want 6a1942", ad); end
  endtask

  task automatic test_tolerance;
    int v0, e0;
    v0 = nvalid; e0 = nerr;
    send_frame(24'h249249, SHORT + 2, LONG + 2, LONG - 2, SHORT - 2, -1);
    checks++; if (ad !== 24'h249249) begin errors++; $display("FAIL tol2_ad got %h want 249249", ad); end
    checks++; if (nvalid - v0 !== 1) begin errors++; $display("FAIL tol2_count got %0d want 1", nvalid - v0); end
    checks++; if (nerr - e0 !== 0) begin errors++; $display("FAIL tol2_err got %0d want 0", nerr - e0); end
    send_frame(24'h5A5A5A, SHORT + 3, LONG + 3, LONG - 3, SHORT - 3, -1);
    checks++; if (nerr - e0 !== 1) begin errors++; $display("FAIL tol3_err got %0d want 1", nerr - e0); end
    checks++; if (ad !== 24'h249249) begin errors++; $display("FAIL tol3_ad got %h want 249249", ad); end
  endtask

  task automatic test_mid_reset;
    int v0, e0;
    v0 = nvalid; e0 = nerr;
    send_frame(24'h5A5A5A, SHORT, LONG, LONG, SHORT, 10);
    checks++; if (ad !== 24'h0) begin errors++; $display("FAIL rst_ad got %h want 000000", ad); end
    checks++; if (nvalid - v0 !== 0) begin errors++; $display("FAIL rst_valid got %0d want 0", nvalid - v0); end
    checks++; if (nerr - e0 !== 0) begin errors++; $display("FAIL rst_err got %0d want 0", nerr - e0); end
    nominal(24'h955555);
    checks++; if (nvalid - v0 !== 1) begin errors++; $display("FAIL rst_next_count got %0d want 1", nvalid - v0); end
    checks++; if (ad !== 24'h955555) begin errors++; $display("FAIL rst_next_ad got %h want 955555", ad); end
  endtask

  task automatic test_match2;
    int v0, e0;
    v0 = nvalid; e0 = nerr;
    level(1'b0, 100);
    nominal(24'h111111);
    nominal(24'h222222);
    checks++; if (nvalid - v0 !== 0) begin errors++; $display("FAIL m2_early got %0d want 0", nvalid - v0); end
    checks++; if (ad !== 24'h0) begin errors++; $display("FAIL m2_early_ad got %h want 000000", ad); end
    nominal(24'h222222);
    checks++; if (nvalid - v0 !== 1) begin errors++; $display("FAIL m2_count got %0d want 1", nvalid - v0); end
    checks++; if (ad !== 24'h222222) begin errors++; $display("FAIL m2_ad got %h want 222222", ad); end
    checks++;
    if (vcyc[v0 % 64] - fall_cyc !== 67) begin
      errors++; $display("FAIL m2_when got %0d want 67", vcyc[v0 % 64] - fall_cyc);
    end
    checks++; if (nerr - e0 !== 0) begin errors++; $display("FAIL m2_err got %0d want 0", nerr - e0); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
`ifdef PT_DEC_MATCH2_EN
    test_match2;
`else
    test_basic;
    test_back_to_back;
    test_bad_code;
    test_tolerance;
    test_mid_reset;
`endif
    checks++; if (nboth !== 0) begin errors++; $display("FAIL strobe_overlap got %0d want 0", nboth); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
